// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Generates stage stall/flush controls and forwarding selects. Tracks data-memory
// wait and halt-drain state, and counts the cycles spent with fetch stalled.
//
// Handshake note: dmem_req (memtoregM | memwriteM) is the request and dmem_ready the
// completion. An access finishes in the cycle in which both are high. Until then the
// pipeline up to M is frozen and W receives a bubble, so no writeback is repeated.
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             memwriteM,
  input  logic             branchD,
  input  logic             pcsrcD,
  input  logic             haltD,
  input  logic             haltW,
  input  logic             dmem_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             stallW,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TIMEOUT = WC_W'(MEM_TIMEOUT);

  state_t          state, state_n;
  logic            ret_drain, ret_drain_n;   // state to resume after a memory wait
  logic [WC_W-1:0] wait_cnt, wait_cnt_n;
  logic            mem_err_n;
  logic            dmem_req, memstall, lwstall, brstall, drain_mode;

  // A register match never counts x0, which is hardwired to zero.
  function automatic logic match(input logic [4:0] x, input logic [4:0] r);
    return (r != 5'd0) && (x == r);
  endfunction

  // Hazard detection terms.
  always_comb begin
    dmem_req = memtoregM | memwriteM;
    memstall = dmem_req & ~dmem_ready;
    lwstall  = memtoregE & regwriteE & (match(rsD, writeregE) | match(rtD, writeregE));
    brstall  = branchD & ((regwriteE & (match(rsD, writeregE) | match(rtD, writeregE)))
                        | (memtoregM & (match(rsD, writeregM) | match(rtD, writeregM))));
  end

  // Forwarding selects; the younger result in M wins over W.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (regwriteM && match(rsE, writeregM))      forwardAE = 2'b10;
    else if (regwriteW && match(rsE, writeregW)) forwardAE = 2'b01;
    if (regwriteM && match(rtE, writeregM))      forwardBE = 2'b10;
    else if (regwriteW && match(rtE, writeregW)) forwardBE = 2'b01;
    forwardAD = regwriteM & match(rsD, writeregM);
    forwardBD = regwriteM & match(rtD, writeregM);
  end

  // Stall/flush outputs by priority; a memory wait that resumes DRAIN keeps draining.
  always_comb begin
    stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0; stallW = 1'b0;
    flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;
    drain_mode = (state == DRAIN) || ((state == MEM_WAIT) && ret_drain);
    halted     = (state == HALTED);
    if (state == HALTED) begin
      stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1; stallW = 1'b1;
    end else if (memstall) begin
      stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1;
      flushW = 1'b1;
    end else if (lwstall || brstall) begin
      stallF = 1'b1; stallD = 1'b1;
      flushE = 1'b1;
    end else begin
      if (pcsrcD) flushD = 1'b1;
      if (drain_mode) begin
        stallF = 1'b1;
        flushD = 1'b1;
      end
    end
  end

  // Next-state logic for the wait/halt FSM and its timeout tracking.
  always_comb begin
    state_n     = state;
    ret_drain_n = ret_drain;
    wait_cnt_n  = wait_cnt;
    mem_err_n   = mem_err;
    unique case (state)
      RUN: begin
        if (memstall) begin
          state_n     = MEM_WAIT;
          ret_drain_n = 1'b0;
        end else if (haltD && !lwstall && !brstall) begin
          state_n = DRAIN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_n    = ret_drain ? DRAIN : RUN;
          wait_cnt_n = '0;
        end else begin
          if (wait_cnt != TIMEOUT) wait_cnt_n = wait_cnt + 1'b1;
          if (wait_cnt_n == TIMEOUT) mem_err_n = 1'b1;
        end
      end
      DRAIN: begin
        if (haltW) begin
          state_n = HALTED;
        end else if (memstall) begin
          state_n     = MEM_WAIT;
          ret_drain_n = 1'b1;
        end
      end
      HALTED: state_n = HALTED;
      default: state_n = RUN;
    endcase
  end

  // State, timeout and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_drain <= 1'b0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_n;
      ret_drain <= ret_drain_n;
      wait_cnt  <= wait_cnt_n;
      mem_err   <= mem_err_n;
    end
  end

  // Stall performance counter; frozen once halted, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         stall_cnt <= '0;
    else if (stallF && state != HALTED) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios followed by randomized traffic,
// each cycle compared against a behavioural model of the control rules.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int TO    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM;
  logic branchD, pcsrcD, haltD, haltW, dmem_ready;
  logic stallF, stallD, stallE, stallM, stallW;
  logic flushD, flushE, flushM, flushW;
  logic [1:0] forwardAE, forwardBE;
  logic forwardAD, forwardBD, halted, mem_err;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  bit m_halted, m_drain, m_wait, m_err;
  int m_wcnt, m_cnt;
  // model expectations for the current cycle
  logic [8:0] e_stall_flush;  // {sF,sD,sE,sM,sW,fD,fE,fM,fW}
  logic [1:0] e_fae, e_fbe;
  logic e_fad, e_fbd, e_ms, e_lw, e_br;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .memwriteM(memwriteM),
    .branchD(branchD), .pcsrcD(pcsrcD), .haltD(haltD), .haltW(haltW),
    .dmem_ready(dmem_ready),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  // clock
  always #5 clk = ~clk;

  function automatic bit mt(input logic [4:0] x, input logic [4:0] r);
    return (r != 0) && (x == r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
    memwriteM = 0; branchD = 0; pcsrcD = 0; haltD = 0; haltW = 0; dmem_ready = 0;
  endtask

  // Derive expected outputs from the control rules and compare everything.
  task automatic compare_now();
    e_ms = (memtoregM | memwriteM) & ~dmem_ready;
    e_lw = memtoregE & regwriteE & (mt(rsD, writeregE) | mt(rtD, writeregE));
    e_br = branchD & ((regwriteE & (mt(rsD, writeregE) | mt(rtD, writeregE)))
                    | (memtoregM & (mt(rsD, writeregM) | mt(rtD, writeregM))));
    if (m_halted)          e_stall_flush = 9'b11111_0000;
    else if (e_ms)         e_stall_flush = 9'b11110_0001;
    else if (e_lw || e_br) e_stall_flush = 9'b11000_0100;
    else if (m_drain)      e_stall_flush = 9'b10000_1000;
    else if (pcsrcD)       e_stall_flush = 9'b00000_1000;
    else                   e_stall_flush = 9'b00000_0000;
    e_fae = (regwriteM && mt(rsE, writeregM)) ? 2'd2 : (regwriteW && mt(rsE, writeregW)) ? 2'd1 : 2'd0;
    e_fbe = (regwriteM && mt(rtE, writeregM)) ? 2'd2 : (regwriteW && mt(rtE, writeregW)) ? 2'd1 : 2'd0;
    e_fad = regwriteM && mt(rsD, writeregM);
    e_fbd = regwriteM && mt(rtD, writeregM);
    chk("stallF", stallF, e_stall_flush[8]);
    chk("stallD", stallD, e_stall_flush[7]);
    chk("stallE", stallE, e_stall_flush[6]);
    chk("stallM", stallM, e_stall_flush[5]);
    chk("stallW", stallW, e_stall_flush[4]);
    chk("flushD", flushD, e_stall_flush[3]);
    chk("flushE", flushE, e_stall_flush[2]);
    chk("flushM", flushM, e_stall_flush[1]);
    chk("flushW", flushW, e_stall_flush[0]);
    chk("forwardAE", forwardAE, e_fae);
    chk("forwardBE", forwardBE, e_fbe);
    chk("forwardAD", forwardAD, e_fad);
    chk("forwardBD", forwardBD, e_fbd);
    chk("halted", halted, m_halted);
    chk("mem_err", mem_err, m_err);
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  // Advance the model by one clock edge using this cycle's inputs.
  task automatic model_edge();
    if (!m_halted && e_stall_flush[8]) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (m_halted) begin
      // terminal
    end else if (m_wait) begin
      if (dmem_ready) begin
        m_wait = 0; m_wcnt = 0;
      end else begin
        if (m_wcnt < TO) m_wcnt++;
        if (m_wcnt >= TO) m_err = 1;
      end
    end else if (m_drain) begin
      if (haltW) begin m_halted = 1; m_drain = 0; end
      else if (e_ms) m_wait = 1;
    end else begin
      if (e_ms) m_wait = 1;
      else if (haltD && !e_lw && !e_br) m_drain = 1;
    end
  endtask

  // inputs are applied just after a negedge; check, take the edge, return to negedge
  task automatic step();
    #1;
    compare_now();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    idle();
    m_halted = 0; m_drain = 0; m_wait = 0; m_err = 0; m_wcnt = 0; m_cnt = 0;
    #1 compare_now();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();

    // load-use: lw x5 in E, rsD = x5 in D
    memtoregE = 1; regwriteE = 1; writeregE = 5; rsD = 5; step();
    idle(); rsE = 5; regwriteW = 1; writeregW = 5; step();
    chk("fwdAE_after_lw", forwardAE, 2'b01);

    // forwarding priority M over W, and x0 never forwarded
    idle(); rsE = 3; rtE = 3; regwriteM = 1; writeregM = 3; regwriteW = 1; writeregW = 3; step();
    rsE = 0; rtE = 0; writeregM = 0; writeregW = 0; step();
    rsD = 7; rtD = 7; writeregM = 7; step();

    // taken branch: flushD alone, then with a load-use hazard in the same cycle
    idle(); branchD = 1; pcsrcD = 1; rsD = 1; rtD = 2; step();
    memtoregE = 1; regwriteE = 1; writeregE = 2; step();
    idle(); branchD = 1; rsD = 4; memtoregM = 1; writeregM = 4; dmem_ready = 1; step();

    // load in M, ready low for 3 cycles, completes on the 4th
    idle(); memtoregM = 1; writeregM = 9;
    repeat (3) step();
    dmem_ready = 1; step();
    idle(); step();

    // store with ready never arriving: mem_err after TO wait cycles, sticky
    memwriteM = 1;
    repeat (TO + 4) step();
    chk("mem_err_sticky", mem_err, 1'b1);
    do_reset();
    chk("mem_err_cleared", mem_err, 1'b0);

    // halt: drain with a mem wait inside, then halt; counter wraps and freezes
    idle(); haltD = 1; step();
    idle(); pcsrcD = 1; repeat (3) step();
    idle(); memtoregM = 1; repeat (2) step();
    dmem_ready = 1; step();
    idle(); repeat (14) step();
    haltW = 1; step();
    idle(); repeat (4) step();
    chk("halted_final", halted, 1'b1);
    do_reset();

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1)); regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1)); memtoregE = 1'($urandom_range(0, 1));
      memtoregM = ($urandom_range(0, 3) == 0); memwriteM = ($urandom_range(0, 5) == 0);
      branchD = 1'($urandom_range(0, 1)); pcsrcD = ($urandom_range(0, 3) == 0);
      haltD = ($urandom_range(0, 29) == 0); haltW = ($urandom_range(0, 14) == 0);
      dmem_ready = ($urandom_range(0, 2) != 0);
      step();
      if (i % 75 == 74) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d observed=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
